imem_loader: RTL
================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter DEPTH, default 64: instruction memory capacity in 32-bit words.
REQ-002 Parameter BASE_ADDR, default 32'h0000_0000: byte address of the first word written.
REQ-003 clk  input  1  system clock; all state updates on the rising edge.
REQ-004 reset  input  1  reset; synchronous and active-high.
REQ-005 in_valid  input  1  byte-stream source has a byte on in_data.
REQ-006 in_data  input  8  program byte.
REQ-007 in_ready  output  1  loader accepts a byte this cycle; transfer occurs when in_valid && in_ready.
REQ-008 im_we  output  1  instruction-memory write strobe, one-cycle pulse per word.
REQ-009 im_addr  output  32  instruction-memory byte address of the write.
REQ-010 im_wdata  output  32  instruction word to write.
REQ-011 word_cnt  output  16  number of words written since reset.
REQ-012 done  output  1  load finished; sticky until reset.
REQ-013 err  output  1  load aborted; sticky until reset.
REQ-014 cpu_run  output  1  equals done && !err; releases the datapath.

Function
REQ-015 The stream format SHALL be: count high byte, count low byte (N words, 16-bit big-endian), then 4N data bytes, each word big-endian (first byte = bits 31:24).
REQ-016 The FSM SHALL have states LEN_HI, LEN_LO, DATA, CSUM, DONE and ERROR; each byte state advances only on an accepted byte.
REQ-017 LEN_HI -> LEN_LO -> (N==0: DONE; N>DEPTH: ERROR; else DATA).
REQ-018 in_ready SHALL be 1 in LEN_HI, LEN_LO, DATA and CSUM, and 0 in DONE and ERROR.
REQ-019 On acceptance of the 4th byte of a word, im_we SHALL pulse high the next cycle, with im_wdata holding the packed word and im_addr = BASE_ADDR + 4*word_cnt (old value); word_cnt increments in that same cycle.
REQ-020 DATA SHALL exit after the N-th word is accepted: to CSUM if the checksum feature is enabled, else to DONE; done rises in the cycle of im_we for the last word.
REQ-021 A stalled source (in_valid=0) SHALL leave all state unchanged; there is no timeout.
REQ-022 im_addr and im_wdata SHALL hold their last values when im_we=0.
REQ-023 Arithmetic on im_addr SHALL be 32-bit, wrapping modulo 2^32.
REQ-024 In DONE and ERROR, incoming bytes SHALL be ignored.

Reset
REQ-025 Reset SHALL force state LEN_HI, im_we=0, im_addr=BASE_ADDR, im_wdata=0, word_cnt=0, done=0, err=0, cpu_run=0, and clear the partial word and checksum.
REQ-026 Reset asserted mid-load SHALL discard the partial word; the next accepted byte is the count high byte.
REQ-027 in_ready SHALL be 0 while reset is high.

Configuration
REQ-028 Macro IMEM_LOADER_CHECKSUM_EN defined: one byte follows the data; it must equal the XOR of all 4N data bytes; match -> DONE, mismatch -> ERROR; N==0 also requires a checksum byte equal to 8'h00.
REQ-029 Macro undefined: the CSUM state and XOR register are absent, and DATA goes directly to DONE.

Structure
REQ-030 Shared package mips_pkg SHALL hold WORD_W=32, the loader state enum, and the count-field width.
REQ-031 Sub-module word_packer SHALL shift accepted bytes into a 32-bit word and flag the 4th byte; the FSM, counters and checksum stay in imem_loader.

Verification
REQ-032 N=2, bytes 00 02 24 08 00 05 AC 08 00 00 -> im_we at 0x0 with 0x24080005, then at 0x4 with 0xAC080000; word_cnt=2; done=1; cpu_run=1.
REQ-033 N=0 (00 00) -> no im_we, done=1 directly after the low byte (checksum off); with the checksum on, a following 00 -> done.
REQ-034 DEPTH=64, count 00 41 -> err=1, cpu_run=0, in_ready=0, no writes.
REQ-035 in_valid toggled randomly across one word -> word still 0x24080005 and exactly one im_we pulse.
REQ-036 Reset after 2 data bytes, then a full N=1 stream -> single write at BASE_ADDR with the new word.
REQ-037 IMEM_LOADER_CHECKSUM_EN, N=1, word 0x01020304, checksum 0x04 -> done; checksum 0x05 -> err=1.

Source files
------------

// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the instruction-memory loader.
//   WORD_W  : instruction word width in bits
//   BYTE_W  : width of one stream byte
//   COUNT_W : width of the big-endian word-count field at the head of a stream
//   loader_state_t : loader FSM state encoding
// -----------------------------------------------------------------------------
package mips_pkg;

    localparam int WORD_W  = 32;
    localparam int BYTE_W  = 8;
    localparam int COUNT_W = 16;

    typedef enum logic [2:0] {
        LEN_HI = 3'd0,
        LEN_LO = 3'd1,
        DATA   = 3'd2,
        CSUM   = 3'd3,
        DONE   = 3'd4,
        ERROR  = 3'd5
    } loader_state_t;

    // States in which the loader consumes bytes from the stream.
    function automatic logic is_byte_state(input loader_state_t s);
        return (s == LEN_HI) || (s == LEN_LO) || (s == DATA) || (s == CSUM);
    endfunction

endpackage

// File: rtl/imem_loader_word_packer.sv
// -----------------------------------------------------------------------------
// word_packer
// Shifts accepted stream bytes into a big-endian 32-bit word.
// Ports:
//   clk, reset : clock, synchronous active-high reset (discards partial word)
//   i_shift    : a byte is accepted this cycle
//   i_byte     : the byte being accepted
//   o_word     : packed word including the byte currently on i_byte
//   o_last     : the byte on i_byte completes the word (4th byte)
// -----------------------------------------------------------------------------
module word_packer
    import mips_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              i_shift,
    input  logic [BYTE_W-1:0] i_byte,
    output logic [WORD_W-1:0] o_word,
    output logic              o_last
);

    // Holds the three earlier bytes of the word; the fourth arrives on i_byte,
    // so the full word is available combinationally in its acceptance cycle.
    logic [WORD_W-BYTE_W-1:0] r_shift;
    logic [1:0]               r_idx;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_shift <= '0;
            r_idx   <= 2'd0;
        end else if (i_shift) begin
            r_shift <= {r_shift[WORD_W-2*BYTE_W-1:0], i_byte};
            r_idx   <= r_idx + 2'd1;
        end
    end

    assign o_word = {r_shift, i_byte};
    assign o_last = (r_idx == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
// Loads a byte stream into instruction memory and then releases the CPU.
// Stream: count hi, count lo (N words), then 4N bytes, each word big-endian.
// With IMEM_LOADER_CHECKSUM_EN defined, a final byte must equal the XOR of
// all data bytes (8'h00 when N == 0); otherwise the load ends after the data.
//
// Handshake: a byte transfers on a rising edge where in_valid && in_ready.
// in_valid may drop at any time; the loader then simply waits (no timeout).
//
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   in_valid/in_data: byte source
//   in_ready        : loader can take a byte (0 in DONE/ERROR and in reset)
//   im_we           : one-cycle write strobe per completed word
//   im_addr/im_wdata: write address (BASE_ADDR + 4*index) and word; held
//   word_cnt        : words written since reset
//   done, err       : sticky completion / abort flags
//   cpu_run         : done && !err
//   dbg_state       : current FSM state (loader_state_t encoding)
// Parameters: DEPTH (capacity in words), BASE_ADDR (byte address of word 0)
// -----------------------------------------------------------------------------
module imem_loader
    import mips_pkg::*;
#(
    parameter int          DEPTH     = 64,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    input  logic [BYTE_W-1:0]  in_data,
    output logic               in_ready,
    output logic               im_we,
    output logic [31:0]        im_addr,
    output logic [WORD_W-1:0]  im_wdata,
    output logic [COUNT_W-1:0] word_cnt,
    output logic               done,
    output logic               err,
    output logic               cpu_run,
    output logic [2:0]         dbg_state
);

    localparam logic [31:0] DEPTH_W = 32'(DEPTH);

    loader_state_t      r_state;
    loader_state_t      w_next_state;
    logic [BYTE_W-1:0]  r_len_hi;
    logic [COUNT_W-1:0] r_count;
    logic [COUNT_W-1:0] r_word_cnt;
    logic               r_im_we;
    logic [31:0]        r_im_addr;
    logic [WORD_W-1:0]  r_im_wdata;
    logic               r_done;
    logic               r_err;

    logic               w_accept;
    logic [COUNT_W-1:0] w_count_field;
    logic               w_count_zero;
    logic               w_count_big;
    logic               w_data_accept;
    logic               w_word_done;
    logic               w_last_word;
    logic [31:0]        w_wr_addr;
    logic [WORD_W-1:0]  w_pk_word;
    logic               w_pk_last;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [BYTE_W-1:0]  r_csum;
    logic               w_csum_ok;
    assign w_csum_ok = (in_data == r_csum);
`endif

    assign in_ready      = !reset && is_byte_state(r_state);
    assign w_accept      = in_valid && in_ready;
    assign w_count_field = {r_len_hi, in_data};
    assign w_count_zero  = (w_count_field == '0);
    assign w_count_big   = ({16'b0, w_count_field} > DEPTH_W);
    assign w_data_accept = w_accept && (r_state == DATA);
    assign w_word_done   = w_data_accept && w_pk_last;
    // r_count >= 1 whenever the FSM is in DATA, so the subtraction cannot wrap.
    assign w_last_word   = (r_word_cnt == r_count - 16'd1);
    assign w_wr_addr     = BASE_ADDR + {14'b0, r_word_cnt, 2'b00};

    word_packer u_packer (
        .clk     (clk),
        .reset   (reset),
        .i_shift (w_data_accept),
        .i_byte  (in_data),
        .o_word  (w_pk_word),
        .o_last  (w_pk_last)
    );

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            LEN_HI: begin
                if (w_accept) w_next_state = LEN_LO;
            end
            LEN_LO: begin
                if (w_accept) begin
                    if (w_count_zero) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        w_next_state = CSUM;
`else
                        w_next_state = DONE;
`endif
                    end else if (w_count_big) begin
                        w_next_state = ERROR;
                    end else begin
                        w_next_state = DATA;
                    end
                end
            end
            DATA: begin
                if (w_word_done && w_last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    w_next_state = CSUM;
`else
                    w_next_state = DONE;
`endif
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CSUM: begin
                if (w_accept) w_next_state = w_csum_ok ? DONE : ERROR;
            end
`endif
            DONE:    w_next_state = DONE;
            ERROR:   w_next_state = ERROR;
            default: w_next_state = ERROR;
        endcase
    end

    // State register and datapath.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= LEN_HI;
            r_len_hi   <= '0;
            r_count    <= '0;
            r_word_cnt <= '0;
            r_im_we    <= 1'b0;
            r_im_addr  <= BASE_ADDR;
            r_im_wdata <= '0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_im_we <= w_word_done;
            if (w_accept && (r_state == LEN_HI)) r_len_hi <= in_data;
            if (w_accept && (r_state == LEN_LO)) r_count  <= w_count_field;
            if (w_word_done) begin
                r_im_addr  <= w_wr_addr;
                r_im_wdata <= w_pk_word;
                r_word_cnt <= r_word_cnt + 16'd1;
            end
            // Flags follow the state entered, so done coincides with the
            // final im_we pulse when no checksum byte is expected.
            if (w_next_state == DONE)  r_done <= 1'b1;
            if (w_next_state == ERROR) r_err  <= 1'b1;
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            r_csum <= '0;
        end else if (w_data_accept) begin
            r_csum <= r_csum ^ in_data;
        end
    end
`endif

    assign im_we     = r_im_we;
    assign im_addr   = r_im_addr;
    assign im_wdata  = r_im_wdata;
    assign word_cnt  = r_word_cnt;
    assign done      = r_done;
    assign err       = r_err;
    assign cpu_run   = r_done && !r_err;
    assign dbg_state = r_state;

endmodule
